// File: rtl/avl_frame_reader_pkg.sv
// Shared types for the Avalon frame reader: FSM encoding, FIFO entry tag and
// small arithmetic helpers.
package frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Sideband stored next to each data word in the return FIFO.
  typedef struct packed {
    logic sof;
    logic eol;
  } entry_tag_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/avl_frame_reader_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count; the head
// word reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    do_rd_s = rd_en && (count_r != CW'(0));
    do_wr_s = wr_en && ((count_r != CW'(DEPTH)) || do_rd_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? AW'(0) : wr_ptr_r + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= (rd_ptr_r == AW'(DEPTH - 1)) ? AW'(0) : rd_ptr_r + AW'(1);
      end
      count_r <= count_r + (do_wr_s ? CW'(1) : CW'(0)) - (do_rd_s ? CW'(1) : CW'(0));
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign empty   = (count_r == CW'(0));
  assign count   = count_r;
  assign rd_data = empty ? WIDTH'(0) : mem_r[rd_ptr_r];

endmodule

// File: rtl/avl_frame_reader.sv
// Frame fetch engine: issues line-bounded Avalon read bursts under FIFO credit
// control and streams the returned words tagged with start-of-frame/end-of-line.
module avl_frame_reader
  import frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 26,
  parameter int WORDS_PER_LINE = 160,
  parameter int LINES          = 480,
  parameter int BURST_LEN      = 8,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  buf_sel,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err,
  input  logic                  avl_ready,
  output logic                  avl_burstbegin,
  output logic                  avl_read_req,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic [6:0]            avl_size,
  input  logic                  avl_read_data_valid,
  input  logic [DATA_WIDTH-1:0] avl_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol
);
  localparam int WORD_W = $clog2(WORDS_PER_LINE + 1);
  localparam int LINE_W = $clog2(LINES + 1);
  localparam int OUT_W  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    entry_tag_t            tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [WORD_W-1:0]     word_r, ret_word_r;
  logic [LINE_W-1:0]     line_r, ret_line_r;
  logic [OUT_W-1:0]      outstanding_r, fifo_count_s;
  logic [31:0]           size_s, credits_s, word_sum_s;
  logic                  line_end_s, frame_end_s, accept_s, wr_s, pop_s;
  logic                  ret_sof_s, ret_eol_s, ret_last_s, fifo_empty_s;
  entry_t                wr_entry_s, rd_entry_s;

  // Burst sizing, credit and end-of-line/frame decode for both directions.
  always_comb begin
    size_s      = min_u32(32'(BURST_LEN), 32'(WORDS_PER_LINE) - 32'(word_r));
    credits_s   = 32'(FIFO_DEPTH) - 32'(fifo_count_s) - 32'(outstanding_r);
    word_sum_s  = 32'(word_r) + size_s;
    line_end_s  = (word_sum_s == 32'(WORDS_PER_LINE));
    frame_end_s = line_end_s && (32'(line_r) == 32'(LINES - 1));
    accept_s    = (state_r == ST_REQ) && avl_ready;
    wr_s        = avl_read_data_valid && (outstanding_r != OUT_W'(0));
    ret_sof_s   = (ret_word_r == WORD_W'(0)) && (ret_line_r == LINE_W'(0));
    ret_eol_s   = (32'(ret_word_r) == 32'(WORDS_PER_LINE - 1));
    ret_last_s  = ret_eol_s && (32'(ret_line_r) == 32'(LINES - 1));
    wr_entry_s  = {ret_sof_s, ret_eol_s, avl_read_data};
    pop_s       = !fifo_empty_s && out_ready;
  end

  // Request FSM: frame start latch, credit wait, Avalon handshake, drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      busy           <= 1'b0;
      addr_r         <= ADDR_WIDTH'(0);
      word_r         <= WORD_W'(0);
      line_r         <= LINE_W'(0);
      avl_burstbegin <= 1'b0;
      avl_read_req   <= 1'b0;
      avl_addr       <= ADDR_WIDTH'(0);
      avl_size       <= 7'd0;
    end else begin
      avl_burstbegin <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_CHECK;
            busy    <= 1'b1;
            addr_r  <= buf_sel ? base_b : base_a;
            word_r  <= WORD_W'(0);
            line_r  <= LINE_W'(0);
          end
        end
        ST_CHECK: begin
          if (credits_s >= size_s) begin
            state_r        <= ST_REQ;
            avl_read_req   <= 1'b1;
            avl_burstbegin <= 1'b1;
            avl_addr       <= addr_r;
            avl_size       <= size_s[6:0];
          end
        end
        ST_REQ: begin
          if (avl_ready) begin
            avl_read_req <= 1'b0;
            addr_r       <= addr_r + ADDR_WIDTH'(size_s);
            if (line_end_s) begin
              word_r <= WORD_W'(0);
              line_r <= line_r + LINE_W'(1);
            end else begin
              word_r <= WORD_W'(word_sum_s);
            end
            state_r <= frame_end_s ? ST_DRAIN : ST_CHECK;
          end
        end
        ST_DRAIN: begin
          if (outstanding_r == OUT_W'(0)) begin
            if (continuous) begin
              state_r <= ST_CHECK;
              addr_r  <= buf_sel ? base_b : base_a;
              word_r  <= WORD_W'(0);
              line_r  <= LINE_W'(0);
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Return path: outstanding words, sof/eol position, sticky error, done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_r <= OUT_W'(0);
      ret_word_r    <= WORD_W'(0);
      ret_line_r    <= LINE_W'(0);
      frame_done    <= 1'b0;
      err           <= 1'b0;
    end else begin
      outstanding_r <= outstanding_r + (accept_s ? OUT_W'(size_s) : OUT_W'(0))
                                     - (wr_s ? OUT_W'(1) : OUT_W'(0));
      frame_done    <= wr_s && ret_last_s;
      err           <= err || (avl_read_data_valid && !wr_s);
      if (wr_s) begin
        if (ret_eol_s) begin
          ret_word_r <= WORD_W'(0);
          ret_line_r <= ret_last_s ? LINE_W'(0) : ret_line_r + LINE_W'(1);
        end else begin
          ret_word_r <= ret_word_r + WORD_W'(1);
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_s),
    .wr_data (wr_entry_s),
    .rd_en   (pop_s),
    .rd_data (rd_entry_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign out_valid = !fifo_empty_s;
  assign out_data  = rd_entry_s.data;
  assign out_sof   = rd_entry_s.tag.sof;
  assign out_eol   = rd_entry_s.tag.eol;

endmodule

// File: tb/tb_avl_frame_reader.sv
// Randomised bench for avl_frame_reader: an Avalon memory responder and a stream
// consumer run in lock-step with the stimulus, checked against a frame model.
module tb_avl_frame_reader;
  localparam int DW = 32, AW = 16, WPL = 10, NL = 2, BL = 4, FD = 8;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, continuous = 1'b0, buf_sel = 1'b0;
  logic [AW-1:0] base_a = 16'h0000, base_b = 16'h0000;
  logic busy, frame_done, err, avl_burstbegin, avl_read_req;
  logic [AW-1:0] avl_addr;
  logic [6:0] avl_size;
  logic avl_ready = 1'b0, avl_read_data_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] avl_read_data = 32'h0;
  logic out_valid, out_sof, out_eol;
  logic [DW-1:0] out_data;

  int checks = 0, failures = 0, done_cnt = 0, ready_low_cnt = 0, hold_limit = -1;
  bit mem_rand = 1'b0, cons_rand = 1'b0, cons_on = 1'b0;
  logic [31:0] seed;
  logic [AW-1:0] ret_q[$];
  logic [22:0] req_log[$], exp_req_q[$];
  logic [33:0] obs_q[$], exp_word_q[$];

  avl_frame_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL), .LINES(NL),
                     .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .buf_sel(buf_sel),
    .base_a(base_a), .base_b(base_b), .busy(busy), .frame_done(frame_done), .err(err),
    .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_read_req(avl_read_req),
    .avl_addr(avl_addr), .avl_size(avl_size), .avl_read_data_valid(avl_read_data_valid),
    .avl_read_data(avl_read_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a ^ seed[15:0], ~a ^ seed[31:16]};
  endfunction

  // Model of one frame: requests never cross a line, words come back in address order.
  task automatic add_frame(input logic [AW-1:0] base);
    for (int l = 0; l < NL; l++) begin
      int w = 0;
      while (w < WPL) begin
        int sz = (WPL - w < BL) ? WPL - w : BL;
        exp_req_q.push_back({16'(int'(base) + l * WPL + w), 7'(sz)});
        w += sz;
      end
    end
    for (int i = 0; i < NL * WPL; i++)
      exp_word_q.push_back({mem_word(16'(int'(base) + i)), (i == 0), ((i % WPL) == WPL - 1)});
  endtask

  task automatic mem_drive();
    if (reset) begin
      avl_ready = 1'b0; avl_read_data_valid = 1'b0; ret_q.delete();
      return;
    end
    if (ret_q.size() != 0 && (!mem_rand || $urandom_range(0, 3) != 0)) begin
      avl_read_data_valid = 1'b1;
      avl_read_data = mem_word(ret_q.pop_front());
    end else begin
      avl_read_data_valid = 1'b0;
      avl_read_data = 32'h0;
    end
    if (ready_low_cnt > 0 && avl_read_req) begin
      avl_ready = 1'b0; ready_low_cnt--;
    end else if (hold_limit >= 0 && req_log.size() >= hold_limit) avl_ready = 1'b0;
    else if (mem_rand) avl_ready = ($urandom_range(0, 2) != 0);
    else avl_ready = 1'b1;
    if (avl_read_req && avl_ready) begin
      req_log.push_back({avl_addr, avl_size});
      for (int i = 0; i < int'(avl_size); i++) ret_q.push_back(avl_addr + 16'(i));
    end
  endtask

  task automatic cons_drive();
    if (reset) out_ready = 1'b0;
    else if (cons_rand) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = cons_on;
    if (out_valid && out_ready) obs_q.push_back({out_data, out_sof, out_eol});
    if (frame_done) done_cnt++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    mem_drive();
    cons_drive();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_to_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && !out_valid && !avl_read_req && ret_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; continuous = 1'b0; buf_sel = 1'b0;
    mem_rand = 1'b0; cons_rand = 1'b0; cons_on = 1'b0; ready_low_cnt = 0; hold_limit = -1;
    tick(); tick(); reset = 1'b0;
    req_log.delete(); obs_q.delete(); ret_q.delete();
    exp_req_q.delete(); exp_word_q.delete(); done_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({busy, frame_done, err} !== 3'b000) begin
      failures++; $display("FAIL reset_status got=%b exp=000", {busy, frame_done, err}); end
    checks++; if ({avl_burstbegin, avl_read_req, avl_addr, avl_size} !== 25'd0) begin
      failures++; $display("FAIL reset_avl got=%h exp=0", {avl_burstbegin, avl_read_req, avl_addr, avl_size}); end
    checks++; if ({out_valid, out_data, out_sof, out_eol} !== 35'd0) begin
      failures++; $display("FAIL reset_stream got=%h exp=0", {out_valid, out_data, out_sof, out_eol}); end
  endtask

  task automatic test_burst_split();
    bit ok;
    do_reset();
    base_a = 16'h0100; mem_rand = 1'b1; cons_rand = 1'b1;
    add_frame(base_a);
    pulse_start();
    checks++; if ({busy, avl_read_req} !== 2'b10) begin
      failures++; $display("FAIL split_check_cycle got=%b exp=10", {busy, avl_read_req}); end
    tick();
    checks++; if ({avl_read_req, avl_burstbegin, avl_addr, avl_size} !== {2'b11, 16'h0100, 7'd4}) begin
      failures++; $display("FAIL split_first_req got=%b%b/%h/%0d exp=11/0100/4",
                           avl_read_req, avl_burstbegin, avl_addr, avl_size); end
    run_to_idle(600, ok);
    checks++; if (!ok) begin failures++; $display("FAIL split_timeout got=busy exp=idle"); end
    checks++; if (req_log.size() != exp_req_q.size()) begin
      failures++; $display("FAIL split_req_count got=%0d exp=%0d", req_log.size(), exp_req_q.size()); end
    foreach (exp_req_q[i]) if (i < req_log.size()) begin
      checks++; if (req_log[i] !== exp_req_q[i]) begin
        failures++; $display("FAIL split_req[%0d] got=%h exp=%h", i, req_log[i], exp_req_q[i]); end
    end
    checks++; if (obs_q.size() != exp_word_q.size()) begin
      failures++; $display("FAIL split_word_count got=%0d exp=%0d", obs_q.size(), exp_word_q.size()); end
    foreach (exp_word_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_word_q[i]) begin
        failures++; $display("FAIL split_word[%0d] got=%h exp=%h", i, obs_q[i], exp_word_q[i]); end
    end
    checks++; if (done_cnt != 1 || err !== 1'b0) begin
      failures++; $display("FAIL split_done got=%0d/err%b exp=1/err0", done_cnt, err); end
  endtask

  task automatic test_credit_limit();
    bit ok;
    logic [AW-1:0] base;
    do_reset();
    base = 16'hFFF0 + 16'($urandom_range(0, 15));
    base_a = base;
    add_frame(base);
    pulse_start();
    for (int i = 0; i < 30; i++) tick();
    checks++; if (req_log.size() != 2 || {busy, avl_read_req, out_valid} !== 3'b101) begin
      failures++; $display("FAIL credit_hold got=%0d/%b exp=2/101", req_log.size(), {busy, avl_read_req, out_valid}); end
    cons_on = 1'b1;
    for (int i = 0; i < 20 && obs_q.size() < 4; i++) tick();
    cons_on = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (obs_q.size() != 4 || req_log.size() != 3) begin
      failures++; $display("FAIL credit_release got=%0d pops/%0d reqs exp=4/3", obs_q.size(), req_log.size()); end
    checks++; if (req_log.size() < 3 || req_log[2] !== {16'(base + 16'd8), 7'd2}) begin
      failures++; $display("FAIL credit_third_req got=%h exp=%h", (req_log.size() < 3) ? 23'd0 : req_log[2],
                           {16'(base + 16'd8), 7'd2}); end
    cons_on = 1'b1;
    run_to_idle(600, ok);
    checks++; if (!ok || obs_q.size() != exp_word_q.size()) begin
      failures++; $display("FAIL credit_words got=%0d exp=%0d", obs_q.size(), exp_word_q.size()); end
    foreach (exp_word_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_word_q[i]) begin
        failures++; $display("FAIL credit_word[%0d] got=%h exp=%h", i, obs_q[i], exp_word_q[i]); end
    end
  endtask

  task automatic test_ready_stall();
    bit ok, stable;
    int hi, bb;
    logic [AW-1:0] a0;
    logic [6:0] s0;
    do_reset();
    base_a = 16'($urandom); cons_rand = 1'b1; ready_low_cnt = 5;
    pulse_start();
    tick();
    hi = 0; bb = 0; stable = 1'b1; a0 = avl_addr; s0 = avl_size;
    for (int i = 0; i < 20 && avl_read_req; i++) begin
      hi++;
      if (avl_burstbegin) bb++;
      if (avl_addr !== a0 || avl_size !== s0) stable = 1'b0;
      tick();
    end
    checks++; if (hi != 6 || bb != 1) begin
      failures++; $display("FAIL stall_cycles got=req%0d/bb%0d exp=req6/bb1", hi, bb); end
    checks++; if (!stable || a0 !== base_a || s0 !== 7'd4) begin
      failures++; $display("FAIL stall_stable got=%b/%h/%0d exp=1/%h/4", stable, a0, s0, base_a); end
    run_to_idle(600, ok);
    checks++; if (!ok || obs_q.size() != NL * WPL || done_cnt != 1) begin
      failures++; $display("FAIL stall_finish got=%0d words/%0d done exp=%0d/1", obs_q.size(), done_cnt, NL * WPL); end
  endtask

  task automatic test_continuous();
    bit ok;
    int busy_low;
    do_reset();
    base_a = 16'($urandom); base_b = 16'h0800; continuous = 1'b1;
    mem_rand = 1'b1; cons_rand = 1'b1;
    add_frame(base_a); add_frame(base_b);
    pulse_start();
    busy_low = 0; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (!busy) busy_low++;
      if (i == 5) buf_sel = 1'b1;
      if (req_log.size() >= 7) begin continuous = 1'b0; ok = 1'b1; break; end
    end
    checks++; if (!ok || busy_low != 0) begin
      failures++; $display("FAIL cont_no_idle got=reached%b/low%0d exp=reached1/low0", ok, busy_low); end
    run_to_idle(2000, ok);
    for (int i = 0; i < 20; i++) tick();
    checks++; if (!ok || busy !== 1'b0 || done_cnt != 2) begin
      failures++; $display("FAIL cont_stop got=busy%b/done%0d exp=busy0/done2", busy, done_cnt); end
    checks++; if (req_log.size() != exp_req_q.size()) begin
      failures++; $display("FAIL cont_req_count got=%0d exp=%0d", req_log.size(), exp_req_q.size()); end
    foreach (exp_req_q[i]) if (i < req_log.size()) begin
      checks++; if (req_log[i] !== exp_req_q[i]) begin
        failures++; $display("FAIL cont_req[%0d] got=%h exp=%h", i, req_log[i], exp_req_q[i]); end
    end
    checks++; if (obs_q.size() != exp_word_q.size()) begin
      failures++; $display("FAIL cont_word_count got=%0d exp=%0d", obs_q.size(), exp_word_q.size()); end
    foreach (exp_word_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_word_q[i]) begin
        failures++; $display("FAIL cont_word[%0d] got=%h exp=%h", i, obs_q[i], exp_word_q[i]); end
    end
  endtask

  task automatic test_spurious_valid();
    do_reset();
    tick();
    avl_read_data_valid = 1'b1; avl_read_data = $urandom;
    tick();
    checks++; if ({err, out_valid} !== 2'b10) begin
      failures++; $display("FAIL spurious_err got=%b exp=10", {err, out_valid}); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if ({err, out_valid, busy} !== 3'b100) begin
      failures++; $display("FAIL spurious_sticky got=%b exp=100", {err, out_valid, busy}); end
    do_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL spurious_clear got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    base_a = 16'($urandom); cons_rand = 1'b1; hold_limit = 2;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (avl_read_req && req_log.size() == 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL midreset_reach got=0 exp=1"); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({busy, frame_done, err, avl_burstbegin, avl_read_req, avl_addr, avl_size,
                   out_valid, out_data, out_sof, out_eol} !== 63'd0) begin
      failures++; $display("FAIL midreset_outputs got=%b%b%b%b%b/%h/%0d/%b/%h exp=all0", busy, frame_done, err,
                           avl_burstbegin, avl_read_req, avl_addr, avl_size, out_valid, out_data); end
    hold_limit = -1; req_log.delete(); obs_q.delete(); done_cnt = 0;
    add_frame(base_a);
    tick();
    pulse_start();
    run_to_idle(600, ok);
    checks++; if (!ok || req_log.size() != exp_req_q.size()) begin
      failures++; $display("FAIL midreset_req_count got=%0d exp=%0d", req_log.size(), exp_req_q.size()); end
    foreach (exp_req_q[i]) if (i < req_log.size()) begin
      checks++; if (req_log[i] !== exp_req_q[i]) begin
        failures++; $display("FAIL midreset_req[%0d] got=%h exp=%h", i, req_log[i], exp_req_q[i]); end
    end
    checks++; if (obs_q.size() != exp_word_q.size() || err !== 1'b0 || done_cnt != 1) begin
      failures++; $display("FAIL midreset_replay got=%0d/err%b/done%0d exp=%0d/err0/done1",
                           obs_q.size(), err, done_cnt, exp_word_q.size()); end
    foreach (exp_word_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_word_q[i]) begin
        failures++; $display("FAIL midreset_word[%0d] got=%h exp=%h", i, obs_q[i], exp_word_q[i]); end
    end
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_burst_split();
    test_credit_limit();
    test_ready_stall();
    test_continuous();
    test_spurious_valid();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
